// File: rtl/coin_encoder.sv
// Coin sensor front end: synchronizes and debounces two raw coin switches, then
// emits a one-cycle coin code (or a collision error) followed by a lockout gap.
//
// state | meaning
// IDLE  | waiting for a debounced rising edge on either coin
// EMIT  | d_out carries the coin code for exactly this cycle
// GAP   | lockout; rise events are dropped until the gap timer expires
module coin_encoder #(
    parameter int unsigned DEB_CYCLES = 4,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       coin_a,
    input  logic       coin_b,
    output logic [1:0] d_out,
    output logic       coin_err,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);
    localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

    // index 0 = coin A, index 1 = coin B
    logic [1:0] sync1;
    logic [1:0] sync2;
    logic [1:0] deb_lvl;
    logic [1:0] rise;
    logic [7:0] deb_cnt [2];

    state_t     state;
    state_t     state_nxt;
    logic [7:0] gap_cnt;
    logic [1:0] d_out_nxt;
    logic       coin_err_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1   <= 2'b00;
            sync2   <= 2'b00;
            deb_lvl <= 2'b00;
            rise    <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                deb_cnt[i] <= 8'd0;
            end
        end else begin
            sync1 <= {coin_b, coin_a};
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                rise[i] <= 1'b0;
                if (sync2[i] == deb_lvl[i]) begin
                    deb_cnt[i] <= 8'd0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    // this sample is the DEB_CYCLES-th consecutive disagreement
                    deb_lvl[i] <= ~deb_lvl[i];
                    deb_cnt[i] <= 8'd0;
                    rise[i]    <= ~deb_lvl[i];
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            gap_cnt  <= 8'd0;
            d_out    <= 2'b00;
            coin_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            d_out    <= d_out_nxt;
            coin_err <= coin_err_nxt;
            if (state_nxt == GAP && state != GAP) begin
                gap_cnt <= GAP_LAST;
            end else if (state == GAP && gap_cnt != 8'd0) begin
                gap_cnt <= gap_cnt - 8'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (rise == 2'b11) begin
                    state_nxt = GAP;
                end else if (rise != 2'b00) begin
                    state_nxt = EMIT;
                end
            end
            EMIT:    state_nxt = GAP;
            GAP: begin
                if (gap_cnt == 8'd0) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered, so codes are decided on the IDLE exit edge.
    always_comb begin
        d_out_nxt    = 2'b00;
        coin_err_nxt = 1'b0;
        if (state == IDLE) begin
            case (rise)
                2'b01:   d_out_nxt    = 2'b01;
                2'b10:   d_out_nxt    = 2'b10;
                2'b11:   coin_err_nxt = 1'b1;
                default: d_out_nxt    = 2'b00;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_coin_encoder.sv
// Bench for coin_encoder: directed scenarios plus randomized coin traffic, all
// compared cycle by cycle against a behavioural model of the encoder rules.
module tb_coin_encoder;

    localparam int DEB = 4;
    localparam int GAPC = 2;
    localparam int MAX_SAMP = 8192;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       coin_a = 1'b0;
    logic       coin_b = 1'b0;
    logic [1:0] d_out;
    logic       coin_err;
    logic       busy;

    coin_encoder #(.DEB_CYCLES(DEB), .GAP_CYCLES(GAPC)) dut (
        .clk      (clk),
        .reset    (reset),
        .coin_a   (coin_a),
        .coin_b   (coin_b),
        .d_out    (d_out),
        .coin_err (coin_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // Synchronizer modelled as a two-sample delay; a debounced level flips once
    // the most recent DEB samples since the last flip/reset all disagree with it.
    bit m_s1 [2];
    bit m_s2 [2];
    bit m_lvl [2];
    bit m_rise [2];
    bit samp [2][MAX_SAMP];
    int nsamp = 0;
    int first_valid [2];
    int busy_left = 0;
    int exp_d = 0;
    int exp_err = 0;
    int exp_busy = 0;

    task automatic model_step(input bit r, input bit a, input bit b);
        bit raw [2];
        bit all_diff;
        raw[0] = a;
        raw[1] = b;
        exp_d   = 0;
        exp_err = 0;
        if (r) begin
            busy_left = 0;
            for (int i = 0; i < 2; i++) begin
                m_s1[i] = 0; m_s2[i] = 0; m_lvl[i] = 0; m_rise[i] = 0;
                first_valid[i] = nsamp;
            end
        end else begin
            if (busy_left == 0) begin
                if (m_rise[0] && m_rise[1]) begin
                    exp_err = 1; busy_left = GAPC;
                end else if (m_rise[0]) begin
                    exp_d = 1; busy_left = GAPC + 1;
                end else if (m_rise[1]) begin
                    exp_d = 2; busy_left = GAPC + 1;
                end
            end else begin
                busy_left--;
            end
            for (int i = 0; i < 2; i++) begin
                samp[i][nsamp] = m_s2[i];
                m_rise[i] = 0;
            end
            nsamp++;
            for (int i = 0; i < 2; i++) begin
                if (nsamp - DEB >= first_valid[i]) begin
                    all_diff = 1;
                    for (int j = nsamp - DEB; j < nsamp; j++)
                        if (samp[i][j] == m_lvl[i]) all_diff = 0;
                    if (all_diff) begin
                        m_lvl[i] = ~m_lvl[i];
                        m_rise[i] = m_lvl[i];
                        first_valid[i] = nsamp;
                    end
                end
            end
            for (int i = 0; i < 2; i++) begin
                m_s2[i] = m_s1[i];
                m_s1[i] = raw[i];
            end
        end
        exp_busy = (busy_left > 0) ? 1 : 0;
    endtask

    // ---------------- per-scenario statistics ----------------
    int idx = 0;
    int cnt_a, cnt_b, cnt_err, cnt_busy, first_a, first_b, first_err;

    task automatic clr_stats();
        idx = 0; cnt_a = 0; cnt_b = 0; cnt_err = 0; cnt_busy = 0;
        first_a = -1; first_b = -1; first_err = -1;
    endtask

    task automatic tick(input bit r, input bit a, input bit b);
        reset = r; coin_a = a; coin_b = b;
        @(posedge clk);
        model_step(r, a, b);
        #1;
        check("d_out", int'(d_out), exp_d);
        check("coin_err", int'(coin_err), exp_err);
        check("busy", int'(busy), exp_busy);
        check("err_with_code", (coin_err === 1'b1 && d_out != 2'b00) ? 1 : 0, 0);
        if (d_out == 2'b01) begin cnt_a++; if (first_a < 0) first_a = idx; end
        if (d_out == 2'b10) begin cnt_b++; if (first_b < 0) first_b = idx; end
        if (coin_err === 1'b1) begin cnt_err++; if (first_err < 0) first_err = idx; end
        if (busy === 1'b1) cnt_busy++;
        idx++;
        cyc++;
    endtask

    task automatic do_reset();
        tick(1, 0, 0);
        tick(1, 0, 0);
        for (int i = 0; i < 4; i++) tick(0, 0, 0);
    endtask

    int hold_a, hold_b;
    bit lvl_a, lvl_b, rr;

    initial begin
        do_reset();
        check("rst_d_out", int'(d_out), 0);
        check("rst_coin_err", int'(coin_err), 0);
        check("rst_busy", int'(busy), 0);

        // coin A held 10 cycles
        clr_stats();
        for (int i = 0; i < 25; i++) tick(0, i < 10, 0);
        check("a_hold_count", cnt_a, 1);
        check("a_hold_latency", first_a, DEB + 2);
        check("a_hold_busy", cnt_busy, GAPC + 1);
        check("a_hold_no_b", cnt_b, 0);

        // coin B glitch shorter than the debounce window
        do_reset();
        clr_stats();
        for (int i = 0; i < 15; i++) tick(0, 0, i < 3);
        check("glitch_codes", cnt_a + cnt_b, 0);
        check("glitch_busy", cnt_busy, 0);

        // both coins on the same edge
        do_reset();
        clr_stats();
        for (int i = 0; i < 25; i++) tick(0, i < 10, i < 10);
        check("both_err_count", cnt_err, 1);
        check("both_err_when", first_err, DEB + 2);
        check("both_codes", cnt_a + cnt_b, 0);

        // coin B rise lands inside the lockout gap
        do_reset();
        clr_stats();
        for (int i = 0; i < 25; i++) tick(0, i < 10, i >= 2 && i < 12);
        check("gap_drop_a", cnt_a, 1);
        check("gap_drop_b", cnt_b, 0);

        // reset on the edge where the B code would appear
        do_reset();
        clr_stats();
        for (int i = 0; i < 20; i++) tick(i == 6 || i == 7, 0, i < 6);
        check("rst_abort_b", cnt_b, 0);
        check("rst_abort_busy", int'(busy), 0);

        // coin A already high when reset falls
        tick(1, 1, 0);
        tick(1, 1, 0);
        clr_stats();
        for (int i = 0; i < 25; i++) tick(0, i < 15, 0);
        check("fresh_count", cnt_a, 1);
        check("fresh_latency", first_a, DEB + 2);

        // bouncing coin A then stable high
        do_reset();
        clr_stats();
        for (int i = 0; i < 30; i++) tick(0, (i < 6) ? ((i % 2) == 0) : (i < 20), 0);
        check("bounce_count", cnt_a, 1);
        check("bounce_latency", first_a, 6 + DEB + 2);

        // coin B rises while coin A is still held
        do_reset();
        clr_stats();
        for (int i = 0; i < 30; i++) tick(0, i < 25, i >= 12 && i < 25);
        check("held_a_count", cnt_a, 1);
        check("held_b_count", cnt_b, 1);

        // randomized traffic with occasional resets
        hold_a = 0; hold_b = 0; lvl_a = 0; lvl_b = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold_a == 0) begin lvl_a = 1'($urandom_range(0, 1)); hold_a = $urandom_range(1, 9); end
            if (hold_b == 0) begin lvl_b = 1'($urandom_range(0, 1)); hold_b = $urandom_range(1, 9); end
            hold_a--; hold_b--;
            rr = ($urandom_range(0, 199) == 0);
            tick(rr, lvl_a, lvl_b);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/coin_encoder.md
COIN_ENCODER -- requirements
Module: coin_encoder

Interface
REQ-001 Parameter DEB_CYCLES, default 4: consecutive sampled cycles a synchronized input must differ from its debounced level before that level flips; legal range 1..255.
REQ-002 Parameter GAP_CYCLES, default 2: lockout cycles after each emitted code or error; legal range 1..255.
REQ-003 Clk  input  1  single clock; all logic on rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 Coin_a  input  1  raw, asynchronous, bouncy sensor for coin A (0.5 unit); high = coin present.
REQ-006 Coin_b  input  1  raw, asynchronous, bouncy sensor for coin B (1 unit); high = coin present.
REQ-007 D_out  output  2  coin code for the vending FSM D_in port: 00 none, 01 coin A, 10 coin B; 11 never driven.
REQ-008 Coin_err  output  1  one-cycle pulse when both coins are detected on the same cycle.
REQ-009 Busy  output  1  high whenever the emit FSM is not in IDLE.

Function
REQ-010 Each raw input shall pass through a 2-flop synchronizer; only the second flop output (s2) feeds further logic.
REQ-011 Each input shall have an 8-bit debounce counter: cleared when s2 equals the debounced level; otherwise incremented; on reaching DEB_CYCLES the debounced level toggles and the counter clears.
REQ-012 A pulse high for fewer than DEB_CYCLES consecutive s2 samples shall leave the debounced level unchanged and produce no output.
REQ-013 A rise event is a 0->1 transition of a debounced level; falling transitions shall produce no output.
REQ-014 Emit FSM states: IDLE, EMIT, GAP.
REQ-015 IDLE: exactly one rise event -> EMIT; both rise events same cycle -> GAP with Coin_err high for that one cycle; no event -> IDLE.
REQ-016 EMIT lasts exactly one cycle: D_out carries the code (01 or 10), then -> GAP.
REQ-017 GAP lasts exactly GAP_CYCLES cycles, then -> IDLE; rise events during GAP are discarded, not queued.
REQ-018 D_out shall be 00 in every state other than EMIT; D_out and Coin_err are registered outputs.
REQ-019 Latency: raw input stable high from sampling edge k (FSM in IDLE) -> D_out valid for the one cycle following edge k+DEB_CYCLES+2 (default: 6 cycles).
REQ-020 A rise event of one coin while the other is still held high (no same-cycle coincidence) shall be accepted normally.
REQ-021 Coin_err and a valid D_out code shall never be asserted on the same cycle.

Reset
REQ-022 Reset high at a rising edge shall clear synchronizers, debounced levels, counters, FSM (to IDLE), D_out=00, Coin_err=0, Busy=0.
REQ-023 Reset mid-EMIT or mid-GAP shall abort the pending code; no pulse after Reset falls unless a new rise event occurs.
REQ-024 A raw input already high when Reset falls shall be treated as a fresh insertion and yield exactly one code DEB_CYCLES+2 cycles after Reset falls.

Verification
REQ-025 Coin_a held high 10 cycles, defaults -> D_out=01 for exactly one cycle, 6 cycles after first sampled high; Busy high 3 cycles (EMIT + 2 GAP).
REQ-026 Coin_b glitch high 3 cycles, then low -> D_out stays 00, Busy stays 0.
REQ-027 Coin_a and Coin_b rise on the same edge, both held 10 cycles -> Coin_err one-cycle pulse, D_out stays 00 throughout.
REQ-028 Coin_a rises; Coin_b rises 1 cycle after D_out=01 (inside GAP) -> Coin_b discarded, only one code (01) emitted.
REQ-029 Coin_b rises, Reset asserted on the cycle D_out=10 would first appear -> no 10 pulse; all outputs 0 after reset.
REQ-030 Coin_a bouncing 1-0-1-0 each cycle for 6 cycles, then stable high -> exactly one 01 pulse, DEB_CYCLES+2 cycles after the stable run starts.
